// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  localparam logic [7:0] SZ_B = 8'd8;
  localparam logic [7:0] SZ_H = 8'd16;
  localparam logic [7:0] SZ_W = 8'd32;
  localparam logic [7:0] SZ_D = 8'd64;

endpackage

// File: rtl/memory_stage_if.sv
// Valid/ready memory port between the memory stage (master) and the memory (slave).
interface memory_stage_if #(
  parameter int unsigned XLEN = 64
);
  localparam int unsigned STRB_W = XLEN / 8;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [XLEN-1:0]   mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wstrb;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/load_align.sv
// Combinational load steering: selects the addressed bytes of an aligned word and
// sign- or zero-extends them to XLEN.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [7:0]      size,
  input  logic            unsign,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    value = shifted;
    case (size)
      SZ_B:    value = {{(XLEN-8){!unsign && shifted[7]}}, shifted[7:0]};
      SZ_H:    value = {{(XLEN-16){!unsign && shifted[15]}}, shifted[15:0]};
      SZ_W:    value = {{(XLEN-32){!unsign && shifted[31]}}, shifted[31:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: latches the EX/MEM bundle, issues loads/stores over a
// valid/ready port, and hands a one-cycle-valid result to writeback.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned REG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EXMEM_ready,
  input  logic [XLEN-1:0]  exmm_aluresult,
  input  logic [XLEN-1:0]  EXMEM_rs2,
  input  logic [REG_W-1:0] dest_reg,
  input  logic             mem_active,
  input  logic             load,
  input  logic [7:0]       ldst_size,
  input  logic             ldst_unsign,
  input  logic             EXMEM_wbactive,
  input  logic             EXMEM_ecall,
  output logic             MEMEX_stall,
  output logic [REG_W-1:0] MEMEX_rd,
  output logic [XLEN-1:0]  MEMEX_rdval,
  output logic             MEMEX_wbactive,
  memory_stage_if.master   mem,
  output logic             MEMWB_ready,
  output logic [REG_W-1:0] MEMWB_rd,
  output logic [XLEN-1:0]  MEMWB_rdval,
  output logic             MEMWB_wbactive,
  output logic             MEMWB_ecall,
  output logic             mem_misalign
);

  localparam int unsigned STRB_W = XLEN / 8;

  state_e state_q, state_d;

  logic             op_valid_q;
  logic [XLEN-1:0]  addr_q, rs2_q;
  logic [REG_W-1:0] rd_q;
  logic             memop_q, load_q, unsign_q, wb_q, ecall_q;
  logic [7:0]       size_q;

  logic            capture, misalign_in, retire_alu, retire_mem, rd_nz, req_active;
  logic [XLEN-1:0] load_val;
  logic [STRB_W:0] strb_run;

  assign capture     = EXMEM_ready && (state_q == IDLE);
  assign misalign_in = mem_active &&
                       (({3'b000, exmm_aluresult[2:0]} + {1'b0, ldst_size[7:3]}) > 6'd8);
  // A latched op sitting in IDLE is either a non-memory op or a rejected misaligned access.
  assign retire_alu  = op_valid_q && (state_q == IDLE);
  assign retire_mem  = (state_q == WAIT) && mem.mem_resp_valid;
  assign rd_nz       = (rd_q != '0);
  assign req_active  = (state_q == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture && mem_active && !misalign_in) state_d = REQ;
      REQ:     if (mem.mem_req_ready) state_d = WAIT;
      WAIT:    if (mem.mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid_q <= 1'b0;
      addr_q     <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      memop_q    <= 1'b0;
      load_q     <= 1'b0;
      size_q     <= '0;
      unsign_q   <= 1'b0;
      wb_q       <= 1'b0;
      ecall_q    <= 1'b0;
    end else if (capture) begin
      op_valid_q <= 1'b1;
      addr_q     <= exmm_aluresult;
      rs2_q      <= EXMEM_rs2;
      rd_q       <= dest_reg;
      memop_q    <= mem_active;
      load_q     <= load;
      size_q     <= ldst_size;
      unsign_q   <= ldst_unsign;
      wb_q       <= EXMEM_wbactive;
      ecall_q    <= EXMEM_ecall;
    end else if (retire_alu || retire_mem) begin
      op_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MEMWB_ready    <= 1'b0;
      MEMWB_rd       <= '0;
      MEMWB_rdval    <= '0;
      MEMWB_wbactive <= 1'b0;
      MEMWB_ecall    <= 1'b0;
      mem_misalign   <= 1'b0;
    end else begin
      MEMWB_ready <= retire_alu || retire_mem;
      if (retire_alu || retire_mem) begin
        MEMWB_rd       <= rd_q;
        MEMWB_ecall    <= ecall_q;
        MEMWB_rdval    <= retire_mem ? (load_q ? load_val : '0) : (memop_q ? '0 : addr_q);
        MEMWB_wbactive <= wb_q && rd_nz && (retire_mem ? load_q : !memop_q);
      end
      if (capture && misalign_in) mem_misalign <= 1'b1;
    end
  end

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata  (mem.mem_resp_rdata),
    .offset (addr_q[2:0]),
    .size   (size_q),
    .unsign (unsign_q),
    .value  (load_val)
  );

  assign MEMEX_stall    = (state_q != IDLE);
  assign MEMEX_rd       = rd_q;
  assign MEMEX_rdval    = addr_q;
  assign MEMEX_wbactive = op_valid_q && !memop_q && wb_q && rd_nz;

  assign strb_run          = ((STRB_W+1)'(1) << size_q[7:3]) - (STRB_W+1)'(1);
  assign mem.mem_req_valid = req_active;
  assign mem.mem_req_we    = req_active && !load_q;
  assign mem.mem_req_addr  = req_active ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem.mem_req_wstrb = req_active ? (strb_run[STRB_W-1:0] << addr_q[2:0]) : '0;
  assign mem.mem_req_wdata = req_active ? (rs2_q << {addr_q[2:0], 3'b000}) : '0;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: transaction-level reference model, per-cycle
// output comparison, directed pins and randomized traffic.
module tb_memory_stage;

  localparam int XLEN  = 64;
  localparam int REG_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             EXMEM_ready = 1'b0;
  logic [XLEN-1:0]  exmm_aluresult = '0;
  logic [XLEN-1:0]  EXMEM_rs2 = '0;
  logic [REG_W-1:0] dest_reg = '0;
  logic             mem_active = 1'b0;
  logic             load = 1'b0;
  logic [7:0]       ldst_size = '0;
  logic             ldst_unsign = 1'b0;
  logic             EXMEM_wbactive = 1'b0;
  logic             EXMEM_ecall = 1'b0;
  logic             MEMEX_stall;
  logic [REG_W-1:0] MEMEX_rd;
  logic [XLEN-1:0]  MEMEX_rdval;
  logic             MEMEX_wbactive;
  logic             MEMWB_ready;
  logic [REG_W-1:0] MEMWB_rd;
  logic [XLEN-1:0]  MEMWB_rdval;
  logic             MEMWB_wbactive;
  logic             MEMWB_ecall;
  logic             mem_misalign;

  memory_stage_if #(.XLEN(XLEN)) mif ();

  memory_stage #(.XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .EXMEM_ready    (EXMEM_ready),
    .exmm_aluresult (exmm_aluresult),
    .EXMEM_rs2      (EXMEM_rs2),
    .dest_reg       (dest_reg),
    .mem_active     (mem_active),
    .load           (load),
    .ldst_size      (ldst_size),
    .ldst_unsign    (ldst_unsign),
    .EXMEM_wbactive (EXMEM_wbactive),
    .EXMEM_ecall    (EXMEM_ecall),
    .MEMEX_stall    (MEMEX_stall),
    .MEMEX_rd       (MEMEX_rd),
    .MEMEX_rdval    (MEMEX_rdval),
    .MEMEX_wbactive (MEMEX_wbactive),
    .mem            (mif),
    .MEMWB_ready    (MEMWB_ready),
    .MEMWB_rd       (MEMWB_rd),
    .MEMWB_rdval    (MEMWB_rdval),
    .MEMWB_wbactive (MEMWB_wbactive),
    .MEMWB_ecall    (MEMWB_ecall),
    .mem_misalign   (mem_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [5:0]  rd;
    logic        mem;
    logic        ld;
    logic [7:0]  size;
    logic        uns;
    logic        wb;
    logic        ecall;
  } op_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the op held by the stage, where its memory transaction stands
  // (0 none, 1 request pending, 2 awaiting response), and the expected writeback.
  op_t         m_op;
  bit          m_valid, m_accepted;
  int          m_phase;
  bit          e_ready, e_wb, e_ecall, e_mis;
  logic [5:0]  e_rd;
  logic [63:0] e_val;
  int          req_cnt, resp_cnt;
  int          cfg_req_wait = -1, cfg_resp_wait = -1;
  bit          rand_mem = 1'b1;
  bit          force_rd_en = 1'b0;
  logic [63:0] force_rd = '0;
  logic [63:0] last_addr, last_wdata;
  logic [7:0]  last_wstrb;
  logic        last_we;

  function automatic int nbytes(input logic [7:0] size);
    return int'(size) / 8;
  endfunction

  function automatic bit misaligned(input op_t o);
    return o.mem && (int'(o.addr[2:0]) + nbytes(o.size) > 8);
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rdata, input int off,
                                           input int nb, input bit uns);
    logic [63:0] v, mask;
    v    = rdata >> (8 * off);
    mask = (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & mask;
    if (!uns && nb < 8 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_reset();
    m_op = '0; m_valid = 0; m_accepted = 0; m_phase = 0;
    e_ready = 0; e_wb = 0; e_ecall = 0; e_mis = 0; e_rd = '0; e_val = '0;
  endtask

  task automatic check_outputs();
    int off, nb;
    logic [63:0] s;
    chk("stall", 64'(MEMEX_stall), 64'(m_phase != 0));
    chk("req_valid", 64'(mif.mem_req_valid), 64'(m_phase == 1));
    if (m_phase == 1) begin
      off = int'(m_op.addr[2:0]);
      nb  = nbytes(m_op.size);
      s   = ((64'd1 << nb) - 64'd1) << off;
      chk("req_addr", mif.mem_req_addr, m_op.addr & ~64'h7);
      chk("req_we", 64'(mif.mem_req_we), 64'(!m_op.ld));
      chk("req_wstrb", 64'(mif.mem_req_wstrb), s);
      chk("req_wdata", mif.mem_req_wdata, m_op.rs2 << (8 * off));
    end
    chk("fwd_wbactive", 64'(MEMEX_wbactive),
        64'(m_valid && !m_op.mem && m_op.wb && m_op.rd != 0));
    if (m_valid && !m_op.mem) begin
      chk("fwd_rd", 64'(MEMEX_rd), 64'(m_op.rd));
      chk("fwd_rdval", MEMEX_rdval, m_op.addr);
    end
    chk("wb_ready", 64'(MEMWB_ready), 64'(e_ready));
    if (e_ready) begin
      chk("wb_rd", 64'(MEMWB_rd), 64'(e_rd));
      chk("wb_active", 64'(MEMWB_wbactive), 64'(e_wb));
      chk("wb_ecall", 64'(MEMWB_ecall), 64'(e_ecall));
      if (e_wb) chk("wb_rdval", MEMWB_rdval, e_val);
    end
    chk("misalign", 64'(mem_misalign), 64'(e_mis));
  endtask

  task automatic responder();
    if (!rand_mem) return;
    if (m_phase == 1) begin
      mif.mem_req_ready = (req_cnt == 0);
      if (req_cnt > 0) req_cnt--;
    end else begin
      mif.mem_req_ready = 1'($urandom_range(0, 1));
    end
    if (m_phase == 2) begin
      mif.mem_resp_valid = (resp_cnt == 0);
      if (resp_cnt > 0) resp_cnt--;
    end else begin
      mif.mem_resp_valid = ($urandom_range(0, 7) == 0);
    end
    mif.mem_resp_rdata = force_rd_en ? force_rd : {$urandom, $urandom};
  endtask

  task automatic model_update();
    int  old_phase;
    bit  cap, nready;
    op_t o;
    if (reset) begin
      model_reset();
      return;
    end
    old_phase = m_phase;
    cap       = EXMEM_ready && (old_phase == 0);
    nready    = 0;
    if (m_valid && old_phase == 0) begin
      nready = 1; e_rd = m_op.rd; e_ecall = m_op.ecall; e_val = m_op.addr;
      e_wb = !m_op.mem && m_op.wb && m_op.rd != 0;
      m_valid = 0;
    end else if (old_phase == 2 && mif.mem_resp_valid) begin
      nready = 1; e_rd = m_op.rd; e_ecall = m_op.ecall;
      e_wb  = m_op.ld && m_op.wb && m_op.rd != 0;
      e_val = exp_load(mif.mem_resp_rdata, int'(m_op.addr[2:0]), nbytes(m_op.size), m_op.uns);
      m_valid = 0;
      m_phase = 0;
    end
    if (old_phase == 1 && mif.mem_req_ready) begin
      m_phase    = 2;
      resp_cnt   = (cfg_resp_wait < 0) ? int'($urandom_range(0, 3)) : cfg_resp_wait;
      last_addr  = mif.mem_req_addr;
      last_wdata = mif.mem_req_wdata;
      last_wstrb = mif.mem_req_wstrb;
      last_we    = mif.mem_req_we;
    end
    e_ready    = nready;
    m_accepted = cap;
    if (cap) begin
      o = '{addr: exmm_aluresult, rs2: EXMEM_rs2, rd: dest_reg, mem: mem_active, ld: load,
            size: ldst_size, uns: ldst_unsign, wb: EXMEM_wbactive, ecall: EXMEM_ecall};
      m_op    = o;
      m_valid = 1;
      if (misaligned(o)) begin
        e_mis = 1;
      end else if (o.mem) begin
        m_phase = 1;
        req_cnt = (cfg_req_wait < 0) ? int'($urandom_range(0, 3)) : cfg_req_wait;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    responder();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t o);
    EXMEM_ready    = 1'b1;
    exmm_aluresult = o.addr;
    EXMEM_rs2      = o.rs2;
    dest_reg       = o.rd;
    mem_active     = o.mem;
    load           = o.ld;
    ldst_size      = o.size;
    ldst_unsign    = o.uns;
    EXMEM_wbactive = o.wb;
    EXMEM_ecall    = o.ecall;
  endtask

  task automatic issue(input op_t o);
    int n = 0;
    drive(o);
    do begin
      step();
      n++;
    end while (!m_accepted && n < 50);
    EXMEM_ready = 1'b0;
    if (!m_accepted) begin
      n_chk++;
      $display("FAIL accept_timeout: got no capture expected capture within 50 cycles");
    end
  endtask

  task automatic wait_retire(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!MEMWB_ready && n < 40);
    chk(name, 64'(MEMWB_ready), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 64'(MEMEX_stall), 64'd0);
    chk({tag, "_fwd_rd"}, 64'(MEMEX_rd), 64'd0);
    chk({tag, "_fwd_val"}, MEMEX_rdval, 64'd0);
    chk({tag, "_fwd_wb"}, 64'(MEMEX_wbactive), 64'd0);
    chk({tag, "_req_valid"}, 64'(mif.mem_req_valid), 64'd0);
    chk({tag, "_req_we"}, 64'(mif.mem_req_we), 64'd0);
    chk({tag, "_req_addr"}, mif.mem_req_addr, 64'd0);
    chk({tag, "_req_wstrb"}, 64'(mif.mem_req_wstrb), 64'd0);
    chk({tag, "_req_wdata"}, mif.mem_req_wdata, 64'd0);
    chk({tag, "_wb_ready"}, 64'(MEMWB_ready), 64'd0);
    chk({tag, "_wb_rd"}, 64'(MEMWB_rd), 64'd0);
    chk({tag, "_wb_val"}, MEMWB_rdval, 64'd0);
    chk({tag, "_wb_active"}, 64'(MEMWB_wbactive), 64'd0);
    chk({tag, "_wb_ecall"}, 64'(MEMWB_ecall), 64'd0);
    chk({tag, "_misalign"}, 64'(mem_misalign), 64'd0);
  endtask

  function automatic op_t mk(input logic [63:0] addr, input logic [63:0] rs2,
                             input logic [5:0] rd, input bit mem, input bit ld,
                             input logic [7:0] size, input bit uns, input bit wb);
    op_t o;
    o = '{addr: addr, rs2: rs2, rd: rd, mem: mem, ld: ld, size: size, uns: uns, wb: wb,
          ecall: 1'b0};
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  nb, off;
    o.mem   = 1'($urandom_range(0, 1));
    o.ld    = 1'($urandom_range(0, 1));
    o.size  = 8'(8 << $urandom_range(0, 3));
    nb      = nbytes(o.size);
    off     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7))
                                          : (int'($urandom_range(0, 7)) / nb) * nb;
    o.addr  = {$urandom, $urandom};
    if (o.mem) o.addr[2:0] = 3'(off);
    o.rs2   = {$urandom, $urandom};
    o.rd    = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    o.uns   = 1'($urandom_range(0, 1));
    o.wb    = ($urandom_range(0, 3) != 0);
    o.ecall = ($urandom_range(0, 7) == 0);
    return o;
  endfunction

  initial begin
    int  n, stall_cnt;
    op_t o;
    mif.mem_req_ready  = 1'b0;
    mif.mem_resp_valid = 1'b0;
    mif.mem_resp_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // ALU op: forwarding the cycle after capture, writeback pulse one cycle later.
    issue(mk(64'd42, 64'd0, 6'd5, 0, 0, 8'd64, 0, 1));
    chk("addi_fwd_rd", 64'(MEMEX_rd), 64'd5);
    chk("addi_fwd_val", MEMEX_rdval, 64'd42);
    chk("addi_fwd_wb", 64'(MEMEX_wbactive), 64'd1);
    chk("addi_no_req", 64'(mif.mem_req_valid), 64'd0);
    step();
    chk("addi_wb_ready", 64'(MEMWB_ready), 64'd1);
    chk("addi_wb_val", MEMWB_rdval, 64'd42);
    step();
    chk("addi_wb_pulse_end", 64'(MEMWB_ready), 64'd0);

    // Signed and unsigned byte loads from offset 3.
    cfg_req_wait = 1; cfg_resp_wait = 1;
    force_rd_en = 1'b1; force_rd = 64'h0000_0000_8000_0000;
    issue(mk(64'h1003, 64'd0, 6'd7, 1, 1, 8'd8, 0, 1));
    wait_retire("lb_retire");
    chk("lb_req_addr", last_addr, 64'h1000);
    chk("lb_val", MEMWB_rdval, 64'hFFFF_FFFF_FFFF_FF80);
    issue(mk(64'h1003, 64'd0, 6'd7, 1, 1, 8'd8, 1, 1));
    wait_retire("lbu_retire");
    chk("lbu_val", MEMWB_rdval, 64'h0000_0000_0000_0080);
    force_rd_en = 1'b0;

    // Halfword store into the top lanes.
    issue(mk(64'h2006, 64'hABCD, 6'd9, 1, 0, 8'd16, 0, 1));
    wait_retire("sh_retire");
    chk("sh_wstrb", 64'(last_wstrb), 64'hC0);
    chk("sh_wdata", last_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_we", 64'(last_we), 64'd1);
    chk("sh_wb_active", 64'(MEMWB_wbactive), 64'd0);

    // Doubleword load with a slow memory; the next bundle must wait for IDLE.
    cfg_req_wait = 3; cfg_resp_wait = 2;
    issue(mk(64'h4000, 64'd0, 6'd10, 1, 1, 8'd64, 0, 1));
    drive(mk(64'd77, 64'd0, 6'd11, 0, 0, 8'd64, 0, 1));
    n = 0; stall_cnt = 0;
    do begin
      step();
      n++;
      if (MEMEX_stall) stall_cnt++;
    end while (!m_accepted && n < 50);
    EXMEM_ready = 1'b0;
    chk("ld_next_capture_cycles", 64'(n), 64'd8);
    chk("ld_dut_stall_cycles", 64'(stall_cnt), 64'd6);
    repeat (3) step();

    // Word load straddling an 8-byte boundary.
    cfg_req_wait = -1; cfg_resp_wait = -1;
    chk("misalign_before", 64'(mem_misalign), 64'd0);
    issue(mk(64'h3006, 64'd0, 6'd12, 1, 1, 8'd32, 0, 1));
    chk("misalign_set", 64'(mem_misalign), 64'd1);
    chk("misalign_no_req", 64'(mif.mem_req_valid), 64'd0);
    step();
    chk("misalign_retire", 64'(MEMWB_ready), 64'd1);
    chk("misalign_wb_active", 64'(MEMWB_wbactive), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      EXMEM_ready = 1'b0;
      exmm_aluresult = {$urandom, $urandom};
      mem_active = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step();
      o = rand_op();
      issue(o);
    end
    repeat (6) step();

    // Reset while a load waits for its response; the late response must be dropped.
    cfg_req_wait = 0; cfg_resp_wait = 10;
    issue(mk(64'h5000, 64'd0, 6'd13, 1, 1, 8'd64, 0, 1));
    n = 0;
    while (m_phase != 2 && n < 20) begin
      step();
      n++;
    end
    step();
    rand_mem = 1'b0;
    mif.mem_resp_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    model_reset();
    step();
    reset = 1'b0;
    mif.mem_resp_valid = 1'b1;
    mif.mem_resp_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    chk("late_resp_no_wb", 64'(MEMWB_ready), 64'd0);
    mif.mem_resp_valid = 1'b0;
    step();
    chk("late_resp_no_wb2", 64'(MEMWB_ready), 64'd0);
    chk("late_resp_idle", 64'(MEMEX_stall), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
